// File: rtl/fu_wb_arbiter_if.sv
// rtl/fu_wb_arbiter_if.sv - issue and write-back bus between the issue stage and fu_wb_arbiter
interface fu_wb_arbiter_if;
  logic        issue_valid;
  logic [2:0]  issue_fu;
  logic [4:0]  issue_rd;
  logic [4:0]  issue_rs1;
  logic [4:0]  issue_rs2;
  logic        issue_use_rs1;
  logic        issue_use_rs2;
  logic        issue_ready;
  logic [4:0]  fu_en;
  logic [4:0]  fu_busy;
  logic [31:0] rd_pending;
  logic        wb_valid;
  logic [2:0]  wb_sel;
  logic [4:0]  wb_rd;

  modport slave (
    input  issue_valid, issue_fu, issue_rd, issue_rs1, issue_rs2, issue_use_rs1, issue_use_rs2,
    output issue_ready, fu_en, fu_busy, rd_pending, wb_valid, wb_sel, wb_rd
  );

  modport master (
    output issue_valid, issue_fu, issue_rd, issue_rs1, issue_rs2, issue_use_rs1, issue_use_rs2,
    input  issue_ready, fu_en, fu_busy, rd_pending, wb_valid, wb_sel, wb_rd
  );
endinterface

// File: rtl/fu_wb_arbiter.sv
// rtl/fu_wb_arbiter.sv - per-unit latency tracking, hazard-gated issue and fixed-priority write-back arbiter
module fu_wb_arbiter #(
  parameter int LAT_ALU  = 1,
  parameter int LAT_MEM  = 2,
  parameter int LAT_MUL  = 7,
  parameter int LAT_DIV  = 24,
  parameter int LAT_JUMP = 1
) (
  input  logic           clk,
  input  logic           rst,
  fu_wb_arbiter_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} slot_state_t;

  slot_state_t r_state     [5];
  slot_state_t w_state_nxt [5];
  logic [4:0]  r_cnt       [5];
  logic [4:0]  w_cnt_nxt   [5];
  logic [4:0]  r_rd        [5];
  logic [31:0] r_pending;
  logic        r_wb_valid;
  logic [2:0]  r_wb_sel;
  logic [4:0]  r_wb_rd;

  logic [7:0]  w_idle;
  logic [7:0]  w_dec;
  logic        w_ready;
  logic [4:0]  w_fu_en;
  logic [4:0]  w_req;
  logic [4:0]  w_gnt;
  logic [2:0]  w_gnt_sel;
  logic [4:0]  w_gnt_rd;
  logic [31:0] w_pend_set;
  logic [31:0] w_pend_clr;

  function automatic logic [4:0] lat_m1(input int idx);
    case (idx)
      0:       return 5'(LAT_ALU - 1);
      1:       return 5'(LAT_MEM - 1);
      2:       return 5'(LAT_MUL - 1);
      3:       return 5'(LAT_DIV - 1);
      default: return 5'(LAT_JUMP - 1);
    endcase
  endfunction

  // Codes 5-7 map onto the zero upper bits of w_idle, so illegal units never issue.
  always_comb begin
    w_idle = 8'd0;
    for (int i = 0; i < 5; i++) w_idle[i] = (r_state[i] == S_IDLE);
    w_dec   = 8'd1 << bus.issue_fu;
    w_ready = w_idle[bus.issue_fu]
              && !(bus.issue_rd != 5'd0 && r_pending[bus.issue_rd])
              && !(bus.issue_use_rs1 && r_pending[bus.issue_rs1])
              && !(bus.issue_use_rs2 && r_pending[bus.issue_rs2]);
    w_fu_en = (bus.issue_valid && w_ready) ? w_dec[4:0] : 5'd0;
  end

  // Fixed priority DIV > MUL > MEM > JUMP > ALU.
  always_comb begin
    w_gnt     = 5'd0;
    w_gnt_sel = 3'd0;
    w_gnt_rd  = 5'd0;
    for (int i = 0; i < 5; i++) w_req[i] = (r_state[i] == S_DONE);
    if      (w_req[3]) w_gnt[3] = 1'b1;
    else if (w_req[2]) w_gnt[2] = 1'b1;
    else if (w_req[1]) w_gnt[1] = 1'b1;
    else if (w_req[4]) w_gnt[4] = 1'b1;
    else if (w_req[0]) w_gnt[0] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (w_gnt[i]) begin
        w_gnt_sel = 3'(i + 1);
        w_gnt_rd  = r_rd[i];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 5; i++) begin
      w_state_nxt[i] = r_state[i];
      w_cnt_nxt[i]   = r_cnt[i];
      case (r_state[i])
        S_IDLE: if (w_fu_en[i]) begin
          w_state_nxt[i] = S_EXEC;
          w_cnt_nxt[i]   = lat_m1(i);
        end
        S_EXEC: if (r_cnt[i] == 5'd0) w_state_nxt[i] = S_DONE;
                else                  w_cnt_nxt[i]   = r_cnt[i] - 5'd1;
        S_DONE: if (w_gnt[i]) w_state_nxt[i] = S_IDLE;
        default: w_state_nxt[i] = S_IDLE;
      endcase
    end
  end

  // A pending bit drops on the edge that ends its write-back cycle, when the register file commits.
  always_comb begin
    w_pend_set = (bus.issue_valid && w_ready && bus.issue_rd != 5'd0) ? (32'd1 << bus.issue_rd) : 32'd0;
    w_pend_clr = r_wb_valid ? (32'd1 << r_wb_rd) : 32'd0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 5; i++) begin
        r_state[i] <= S_IDLE;
        r_cnt[i]   <= 5'd0;
        r_rd[i]    <= 5'd0;
      end
      r_pending  <= 32'd0;
      r_wb_valid <= 1'b0;
      r_wb_sel   <= 3'd0;
      r_wb_rd    <= 5'd0;
    end else begin
      for (int i = 0; i < 5; i++) begin
        r_state[i] <= w_state_nxt[i];
        r_cnt[i]   <= w_cnt_nxt[i];
        if (w_fu_en[i]) r_rd[i] <= bus.issue_rd;
      end
      r_pending  <= ((r_pending & ~w_pend_clr) | w_pend_set) & ~32'd1;
      r_wb_valid <= (w_gnt != 5'd0);
      r_wb_sel   <= w_gnt_sel;
      r_wb_rd    <= w_gnt_rd;
    end
  end

  assert property (@(posedge clk) disable iff (rst) (w_pend_set & w_pend_clr) == 32'd0);

  always_comb begin
    bus.issue_ready = w_ready;
    bus.fu_en       = w_fu_en;
    for (int i = 0; i < 5; i++) bus.fu_busy[i] = (r_state[i] != S_IDLE);
    bus.rd_pending  = r_pending;
    bus.wb_valid    = r_wb_valid;
    bus.wb_sel      = r_wb_sel;
    bus.wb_rd       = r_wb_rd;
  end

endmodule

// File: doc/fu_wb_arbiter.md
Name: fu_wb_arbiter

Overview:
- Issue-side scheduler and write-back arbiter for the five functional units (ALU, MEM, MUL, DIV, JUMP).
- Tracks one in-flight operation per unit using per-unit latency counters.
- Blocks issue on structural, RAW and WAW hazards via a pending-destination bitmap.
- Shares the single register-file write port among finished units; outputs a registered write-back select, in the same encoding as the write-data mux, plus the destination register.

Parameters:
LAT_ALU, 1, cycles from issue to ALU result ready (1..31)
LAT_MEM, 2, MEM latency
LAT_MUL, 7, MUL latency
LAT_DIV, 24, DIV latency
LAT_JUMP, 1, JUMP latency

Ports:
clk  in  1  clock; all state changes on rising edge
rst  in  1  asynchronous active-high reset
issue_valid  in  1  issue stage presents an instruction
issue_fu  in  3  unit select: 0 ALU, 1 MEM, 2 MUL, 3 DIV, 4 JUMP; 5-7 illegal
issue_rd  in  5  destination register; 0 = no write
issue_rs1  in  5  source register 1
issue_rs2  in  5  source register 2
issue_use_rs1  in  1  instruction reads rs1
issue_use_rs2  in  1  instruction reads rs2
issue_ready  out  1  issue accepted this edge if issue_valid also high (combinational)
fu_en  out  5  one-hot pulse, bit = issue_fu, high when issue_valid && issue_ready (combinational)
fu_busy  out  5  per-unit slot not IDLE
rd_pending  out  32  bitmap of destinations awaiting write-back; bit 0 always 0
wb_valid  out  1  register-file write enable (registered)
wb_sel  out  3  write-data select: 1 ALU, 2 MEM, 3 MUL, 4 DIV, 5 JUMP; 0 when idle
wb_rd  out  5  write address; 0 when idle

Behaviour:
- Reset (async, while rst=1): all slots IDLE, counters 0, rd_pending=0, wb_valid=0, wb_sel=0, wb_rd=0, fu_busy=0.
- Per-slot FSM:
  - IDLE -> EXEC on an accepting edge; the counter loads LAT-1 and the slot latches rd.
  - EXEC: counter decrements each edge; at count 0, next edge -> DONE.
  - DONE: slot asserts an internal request; on the edge at which it is granted -> IDLE.
- issue_ready = issue_fu<5 && slot[issue_fu]==IDLE && !(issue_rd!=0 && rd_pending[issue_rd]) && !(issue_use_rs1 && rd_pending[issue_rs1]) && !(issue_use_rs2 && rd_pending[issue_rs2]).
  - A DONE or EXEC slot never accepts, even if it is granted in the same cycle; this gives a 1-cycle bubble.
- Arbitration among DONE slots:
  - Fixed priority DIV > MUL > MEM > JUMP > ALU; one grant per cycle.
  - Each unit holds at most one result, so worst-case wait is 4 cycles and starvation is impossible.
- Grant at edge E: wb_valid=1, wb_sel=code, wb_rd=slot rd for the cycle after E. With no grant, wb_valid=0 and wb_sel/wb_rd=0.
- Slot with rd=0: still arbitrated and written with wb_valid=1, wb_rd=0; the register file ignores x0.
- rd_pending:
  - Bit set on the accepting edge when rd!=0.
  - Bit cleared on the edge ending the cycle in which wb_valid=1 with that wb_rd, i.e. the same edge the register file writes.
  - A set and a clear of the same bit on one edge is impossible because WAW blocks the issue; this is covered by an assertion.
- Uncontended latency: issue edge E0 -> wb_valid high in the cycle after edge E0+LAT+1.
- Reset mid-operation: all in-flight work is discarded immediately, with no write-back.
- Illegal issue_fu: issue_ready=0, fu_en=0, no state change.

Test Plan:
- Reset during DIV EXEC (count 10) -> fu_busy=0, rd_pending=0, wb_valid=0 immediately; no write-back afterwards.
- Issue ALU rd=5 at edge 0 -> fu_en=5'b00001 at issue; rd_pending[5]=1 after edge 0; wb_valid=1, wb_sel=1, wb_rd=5 in the cycle after edge 2; rd_pending[5]=0 after edge 3.
- Issue DIV rd=3, then MUL rd=4 timed so both reach DONE in the same cycle -> DIV written first (wb_sel=4, rd=3), MUL next cycle (wb_sel=3, rd=4); MUL slot stays DONE one extra cycle.
- RAW: MUL rd=7 in flight; ALU with use_rs1, rs1=7 -> issue_ready=0 until the edge ending MUL write-back, then issue_ready=1.
- Structural/WAW: second MEM while MEM is busy -> issue_ready=0; ALU rd=9 while JUMP rd=9 is pending -> issue_ready=0. issue_fu=6 -> issue_ready=0, no state change.
- Simultaneous DONE of all five units -> five consecutive wb cycles with wb_sel order 4,3,2,5,1; no cycle has wb_valid=0 in between.
